// File: rtl/lcd_init_pkg.sv
// Purpose: shared types and the default ST7735 power-up table for lcd_init_seq.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_e, entry_type_e, 10-bit entry_t {etype[9:8], bval[7:0]},
//   NumEntries, INIT_TABLE, entry_is_byte() helper.
package lcd_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LO,
    ST_RST_WAIT,
    ST_FETCH,
    ST_SEND,
    ST_DRAIN,
    ST_DELAY,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ENT_CMD   = 2'd0,
    ENT_DATA  = 2'd1,
    ENT_DELAY = 2'd2,
    ENT_END   = 2'd3
  } entry_type_e;

  // bval is the SPI byte for CMD/DATA and the wait in milliseconds for DELAY.
  typedef struct packed {
    entry_type_e etype;
    logic [7:0]  bval;
  } entry_t;

  localparam int unsigned NumEntries = 14;

  localparam entry_t INIT_TABLE [NumEntries] = '{
    '{ENT_CMD,   8'h01},   // SWRESET
    '{ENT_DELAY, 8'd150},
    '{ENT_CMD,   8'h11},   // SLPOUT
    '{ENT_DELAY, 8'd255},
    '{ENT_CMD,   8'h3A},   // COLMOD
    '{ENT_DATA,  8'h05},   //   16 bpp
    '{ENT_CMD,   8'h36},   // MADCTL
    '{ENT_DATA,  8'hC0},   //   row/col mirror
    '{ENT_CMD,   8'h21},   // INVON
    '{ENT_CMD,   8'h13},   // NORON
    '{ENT_DELAY, 8'd10},
    '{ENT_CMD,   8'h29},   // DISPON
    '{ENT_DELAY, 8'd100},
    '{ENT_END,   8'h00}
  };

  // True for entries that put a byte on the SPI bus.
  function automatic logic entry_is_byte(entry_t e);
    return (e.etype == ENT_CMD) || (e.etype == ENT_DATA);
  endfunction

endpackage

// File: rtl/lcd_init_timer.sv
// Purpose: microsecond prescaler feeding an 18-bit down-counter for the init sequencer.
// Latency: load N expires on the N-th us tick after load (N=0 behaves like N=1).
// Backpressure: none; expired is a single-cycle combinational pulse, load wins over it.
// Ports: clk_sys_i/rst_sys_i (async, active-high), load + load_val (us), expired.
module lcd_init_timer #(
  parameter int unsigned ClkFreqHz = 50_000_000
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic        load,
  input  logic [17:0] load_val,
  output logic        expired
);

  localparam int unsigned TickCycles = (ClkFreqHz / 1_000_000 > 0) ? ClkFreqHz / 1_000_000 : 1;
  localparam int unsigned PreW       = (TickCycles > 1) ? $clog2(TickCycles) : 1;

  logic [PreW-1:0] pre_q;
  logic [17:0]     cnt_q;
  logic            run_q;
  logic            tick;

  assign tick    = run_q && (pre_q == PreW'(TickCycles - 1));
  assign expired = tick && (cnt_q <= 18'd1);

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      pre_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      // Restarting the prescaler makes every interval a whole number of us.
      pre_q <= '0;
      cnt_q <= load_val;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (tick) begin
        pre_q <= '0;
        if (expired) run_q <= 1'b0;
        else         cnt_q <= cnt_q - 18'd1;
      end else begin
        pre_q <= pre_q + PreW'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_init_seq.sv
// Purpose: LCD power-up sequencer: reset pulse, settle wait, table of cmd/data/delay bytes to SPI TX.
// Latency: dc/cs lead spi_tx_valid_o by one cycle; one SPI byte per FETCH/SEND/DRAIN round.
// Backpressure: holds valid/data/dc until spi_tx_ready_i; waits for spi_idle_i before the next entry.
// Ports: clk_sys_i, rst_sys_i (async, active-high), start_i, busy_o/done_o/err_o,
//   spi_tx_valid_o/spi_tx_data_o/spi_tx_ready_i/spi_idle_i, sw_rst_ni/sw_cs_ni/sw_dc_i,
//   lcd_rst_no/lcd_cs_no/lcd_dc_o. Optional macro LCD_INIT_TIMEOUT_EN enables the SEND timeout.
module lcd_init_seq
  import lcd_init_pkg::*;
#(
  parameter int unsigned ClkFreqHz     = 50_000_000,
  parameter int unsigned RstPulseUs    = 10,
  parameter int unsigned RstWaitUs     = 120_000,
  parameter int unsigned TimeoutCycles = 65_535,
  parameter int unsigned TableLen      = lcd_init_pkg::NumEntries,
  parameter entry_t      InitTable [TableLen] = lcd_init_pkg::INIT_TABLE
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       spi_tx_valid_o,
  output logic [7:0] spi_tx_data_o,
  input  logic       spi_tx_ready_i,
  input  logic       spi_idle_i,
  input  logic       sw_rst_ni,
  input  logic       sw_cs_ni,
  input  logic       sw_dc_i,
  output logic       lcd_rst_no,
  output logic       lcd_cs_no,
  output logic       lcd_dc_o
);

  localparam int unsigned IdxW = (TableLen > 1) ? $clog2(TableLen) : 1;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            rst_n_q, rst_n_d;
  logic            cs_n_q, cs_n_d;
  logic            dc_q, dc_d;
  logic            vld_q, vld_d;
  logic [7:0]      dat_q, dat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            tmr_load;
  logic [17:0]     tmr_val;
  logic            tmr_expired;

  entry_t          cur;
  logic            tx_hs;
  logic            start_ok;
  logic            timeout_hit;

  // idx is advanced on the SEND handshake, so in DRAIN cur is already the next entry.
  assign cur      = InitTable[idx_q];
  assign tx_hs    = vld_q && spi_tx_ready_i;
  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  lcd_init_timer #(
    .ClkFreqHz (ClkFreqHz)
  ) u_timer (
    .clk_sys_i (clk_sys_i),
    .rst_sys_i (rst_sys_i),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expired   (tmr_expired)
  );

`ifdef LCD_INIT_TIMEOUT_EN
  localparam int unsigned ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [ToW-1:0] to_cnt_q;
  logic           err_q;

  // The counter restarts on every SEND entry, so the limit applies per byte.
  assign timeout_hit = (state_q == ST_SEND) && !tx_hs && (to_cnt_q == ToW'(TimeoutCycles - 1));

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_SEND) to_cnt_q <= to_cnt_q + ToW'(1);
      else                    to_cnt_q <= '0;
      if (timeout_hit)   err_q <= 1'b1;
      else if (start_ok) err_q <= 1'b0;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
  assign unused_timeout_cfg = ^TimeoutCycles;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rst_n_d  = rst_n_q;
    cs_n_d   = cs_n_q;
    dc_d     = dc_q;
    vld_d    = vld_q;
    dat_d    = dat_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          rst_n_d = sw_rst_ni;
          cs_n_d  = sw_cs_ni;
          dc_d    = sw_dc_i;
        end
        if (start_ok) begin
          state_d  = ST_RST_LO;
          idx_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          rst_n_d  = 1'b0;
          cs_n_d   = 1'b1;
          dc_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = 18'(RstPulseUs);
        end
      end

      ST_RST_LO: begin
        if (tmr_expired) begin
          state_d  = ST_RST_WAIT;
          rst_n_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = 18'(RstWaitUs);
        end
      end

      ST_RST_WAIT: begin
        if (tmr_expired) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (entry_is_byte(cur)) begin
          // dc/cs/data are registered here so they settle a cycle before valid.
          state_d = ST_SEND;
          dc_d    = (cur.etype == ENT_DATA);
          dat_d   = cur.bval;
          cs_n_d  = 1'b0;
        end else if (cur.etype == ENT_DELAY) begin
          state_d  = ST_DELAY;
          cs_n_d   = 1'b1;
          idx_d    = idx_q + IdxW'(1);
          tmr_load = 1'b1;
          tmr_val  = 18'(cur.bval) * 18'd1000;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rst_n_d = sw_rst_ni;
          cs_n_d  = sw_cs_ni;
          dc_d    = sw_dc_i;
        end
      end

      ST_SEND: begin
        vld_d = 1'b1;
        if (tx_hs) begin
          state_d = ST_DRAIN;
          vld_d   = 1'b0;
          idx_d   = idx_q + IdxW'(1);
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          vld_d   = 1'b0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      ST_DRAIN: begin
        // A DATA entry continues the current transaction, so cs stays asserted.
        if (spi_idle_i) begin
          state_d = ST_FETCH;
          if (cur.etype != ENT_DATA) cs_n_d = 1'b1;
        end
      end

      ST_DELAY: begin
        if (tmr_expired) state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rst_n_q <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign lcd_rst_no     = rst_n_q;
  assign lcd_cs_no      = cs_n_q;
  assign lcd_dc_o       = dc_q;
  assign spi_tx_valid_o = vld_q;
  assign spi_tx_data_o  = dat_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Purpose: directed self-checking bench for lcd_init_seq (4 MHz clock, 2 us pulse, 5 us wait).
// Latency: n/a.
// Backpressure: drives spi_tx_ready_i low for stall and timeout scenarios.
module tb_lcd_init_seq;
  import lcd_init_pkg::*;

  localparam entry_t TEST_TABLE [5] = '{
    '{ENT_CMD,   8'h11},
    '{ENT_DELAY, 8'h02},
    '{ENT_CMD,   8'h3A},
    '{ENT_DATA,  8'h05},
    '{ENT_END,   8'h00}
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic       idle = 1'b1;
  logic       sw_rst_n = 1'b0;
  logic       sw_cs_n = 1'b1;
  logic       sw_dc = 1'b0;
  logic       busy, done, err, valid, rst_no, cs_no, dc;
  logic [7:0] data;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cs_bad = 0;
  logic [8:0] sent_q [$];

  initial forever #5 clk = ~clk;

  lcd_init_seq #(
    .ClkFreqHz     (4_000_000),
    .RstPulseUs    (2),
    .RstWaitUs     (5),
    .TimeoutCycles (100),
    .TableLen      (5),
    .InitTable     (TEST_TABLE)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst),
    .start_i        (start),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .spi_tx_valid_o (valid),
    .spi_tx_data_o  (data),
    .spi_tx_ready_i (ready),
    .spi_idle_i     (idle),
    .sw_rst_ni      (sw_rst_n),
    .sw_cs_ni       (sw_cs_n),
    .sw_dc_i        (sw_dc),
    .lcd_rst_no     (rst_no),
    .lcd_cs_no      (cs_no),
    .lcd_dc_o       (dc)
  );

  // Byte log: {dc, data} of every accepted SPI byte.
  always @(posedge clk) begin
    if (!rst && valid && ready) begin
      sent_q.push_back({dc, data});
      if (cs_no) cs_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    int bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_pins", {rst_no, cs_no, dc, valid, busy, done, err}, 7'b0100000);
    check("reset_data", data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_flags", {busy, done}, 2'b00);

    // Run 1: reset pulse, settle wait, bytes with delay and stall
    pulse_start();
    check("start_busy", {busy, rst_no}, 2'b10);
    cnt = 0;
    while (rst_no === 1'b0 && cnt < 100) begin cnt++; @(negedge clk); end
    check_range("rst_lo_len", cnt, 7, 9);
    check("rst_released", rst_no, 1'b1);
    cnt = 0;
    while (cs_no === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    check_range("rst_hi_len", cnt, 20, 22);

    // First byte goes through, then cs rises for the 2 ms delay.
    cnt = 0;
    while (cs_no === 1'b0 && cnt < 50) begin cnt++; @(negedge clk); end
    cnt = 0;
    bad = 0;
    while (cs_no === 1'b1 && cnt < 9000) begin
      if (valid !== 1'b0) bad++;
      cnt++;
      @(negedge clk);
    end
    check_range("delay_len", cnt, 7996, 8004);
    check("delay_no_valid", bad, 0);

    // Stall byte 2 for 20 cycles.
    ready = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({valid, data, dc, cs_no} !== {1'b1, 8'h3A, 1'b0, 1'b0}) bad++;
    end
    check("stall_stable", bad, 0);
    check("stall_no_accept", sent_q.size(), 1);
    ready = 1'b1;

    cnt = 0;
    while (done !== 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    check("run1_done", {done, busy, err}, 3'b100);
    check("run1_count", sent_q.size(), 3);
    check("run1_bytes", {sent_q[0], sent_q[1], sent_q[2]}, {9'h011, 9'h03A, 9'h105});
    check("cs_at_handshake", cs_bad, 0);

    // Pins follow software GPO after done.
    sw_rst_n = 1'b1; sw_cs_n = 1'b0; sw_dc = 1'b1;
    @(negedge clk);
    check("sw_pins_a", {rst_no, cs_no, dc}, 3'b101);
    sw_rst_n = 1'b0; sw_cs_n = 1'b1; sw_dc = 1'b1;
    @(negedge clk);
    check("sw_pins_b", {rst_no, cs_no, dc}, 3'b011);

    // Run 2: restart from DONE, spurious start while busy.
    sent_q.delete();
    pulse_start();
    check("restart_flags", {done, busy, rst_no}, 3'b010);
    cnt = 0;
    while (rst_no === 1'b0 && cnt < 100) begin
      start = (cnt == 3);
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check_range("rst_lo_busy_start", cnt, 7, 9);
    cnt = 0;
    while (done !== 1'b1 && cnt < 10000) begin cnt++; @(negedge clk); end
    check("run2_done", {done, busy}, 2'b10);
    check("run2_bytes", {sent_q[0], sent_q[1], sent_q[2]}, {9'h011, 9'h03A, 9'h105});
    check("run2_count", sent_q.size(), 3);

    // Run 3: reset in the middle of SEND.
    ready = 1'b0;
    pulse_start();
    cnt = 0;
    while (valid !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    check("run3_in_send", valid, 1'b1);
    rst = 1'b1;
    #1;
    check("midrun_reset_pins", {rst_no, cs_no, dc, valid, busy, done, err}, 7'b0100000);
    check("midrun_reset_data", data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    sent_q.delete();
    @(negedge clk);
    pulse_start();
    cnt = 0;
    while (sent_q.size() == 0 && cnt < 100) begin cnt++; @(negedge clk); end
    check("restart_first_byte", sent_q[0], 9'h011);
    check("restart_busy", busy, 1'b1);

`ifdef LCD_INIT_TIMEOUT_EN
    // Timeout: ready stuck low.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b0;
    pulse_start();
    cnt = 0;
    while (valid !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    cnt = 0;
    while (err !== 1'b1 && cnt < 300) begin cnt++; @(negedge clk); end
    check_range("timeout_len", cnt, 98, 101);
    check("timeout_flags", {err, done, valid, cs_no, busy}, 5'b11010);
    pulse_start();
    check("timeout_clear", {err, done}, 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
